regfile_sb: RTL and testbench

- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds synchronous reset of all registers, write-to-read bypass, and a per-register busy scoreboard for the pipelined/multicycle datapath.
- Sits between decode (read ports, issue marking) and writeback (write port).
- Produces a hazard flag that decode uses to stall.

---
 rtl/regfile_sb.sv | 81 ++++++++
 tb/tb_regfile_sb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read / 1-write integer register file with
// synchronous reset, optional write-to-read bypass and a per-register busy
// scoreboard. Decode drives the read ports and the issue port and stalls on
// hazard; writeback drives the write port.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high; clears registers, busy bits, npend
//   regw/waddr/wdata  write port (address 0 discarded, clears busy[waddr])
//   rR1/rR2       read addresses
//   dR1/dR2       combinational read data (x0 reads 0, optional bypass)
//   issue/iaddr   mark destination busy (ignored while hazard, and for x0)
//   hazard        a read operand is pending and not covered by bypass
//   npend         registered count of busy registers
module regfile_sb #(
  parameter int n      = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          regw,
  input  logic [AW-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic [AW-1:0] rR1,
  input  logic [AW-1:0] rR2,
  output logic [n-1:0]  dR1,
  output logic [n-1:0]  dR2,
  input  logic          issue,
  input  logic [AW-1:0] iaddr,
  output logic          hazard,
  output logic [AW:0]   npend
);
  localparam int NREGS = 1 << AW;

  logic [NREGS-1:0][n-1:0] regs;
  logic [NREGS-1:0]        busy;

  logic byp1, byp2, p1, p2;
  logic wr_en, set_en, inc, dec;

  // Bypass only ever matters for a nonzero address; x0 is forced below.
  assign byp1 = (BYPASS != 0) && regw && (waddr == rR1);
  assign byp2 = (BYPASS != 0) && regw && (waddr == rR2);

  always_comb begin
    dR1 = '0;
    dR2 = '0;
    if (rR1 != '0) dR1 = byp1 ? wdata : regs[rR1];
    if (rR2 != '0) dR2 = byp2 ? wdata : regs[rR2];
  end

  assign p1     = (rR1 != '0) && busy[rR1] && !byp1;
  assign p2     = (rR2 != '0) && busy[rR2] && !byp2;
  assign hazard = p1 || p2;

  assign wr_en  = regw && (waddr != '0);
  assign set_en = issue && !hazard && (iaddr != '0);

  // npend tracks actual busy-bit transitions so it always equals popcount.
  // A set and clear on the same address leave the bit set: the clear never
  // happens, so it must not decrement.
  assign inc = set_en && !busy[iaddr];
  assign dec = wr_en && busy[waddr] && !(set_en && (iaddr == waddr));

  always_ff @(posedge clock) begin
    if (reset) begin
      regs  <= '0;
      busy  <= '0;
      npend <= '0;
    end else begin
      if (wr_en) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      // Issue after write so a new producer supersedes the completing one.
      if (set_en) busy[iaddr] <= 1'b1;
      npend <= npend + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
module tb_regfile_sb;
  logic        clock, reset, regw, issue;
  logic [4:0]  waddr, rR1, rR2, iaddr;
  logic [31:0] wdata;
  logic [31:0] dR1, dR2, nb_dR1, nb_dR2;
  logic        hazard, nb_hazard;
  logic [5:0]  npend, nb_npend;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.n(32), .AW(5), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .regw(regw), .waddr(waddr), .wdata(wdata),
    .rR1(rR1), .rR2(rR2), .dR1(dR1), .dR2(dR2), .issue(issue), .iaddr(iaddr),
    .hazard(hazard), .npend(npend)
  );

  regfile_sb #(.n(32), .AW(5), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .regw(regw), .waddr(waddr), .wdata(wdata),
    .rR1(rR1), .rR2(rR2), .dR1(nb_dR1), .dR2(nb_dR2), .issue(issue), .iaddr(iaddr),
    .hazard(nb_hazard), .npend(nb_npend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    regw = 0; waddr = 0; wdata = 0; issue = 0; iaddr = 0; rR1 = 0; rR2 = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;

    // Reset state: every address reads zero, no hazard, no pending.
    chk("rst_npend", npend, 0);
    for (int a = 0; a < 32; a++) begin
      rR1 = 5'(a); rR2 = 5'(a);
      #2;
      chk($sformatf("rst_dR1_%0d", a), dR1, 0);
      chk($sformatf("rst_dR2_%0d", a), dR2, 0);
      chk($sformatf("rst_hz_%0d", a), hazard, 0);
      tick();
    end

    // x0 write is discarded, no bypass to x0.
    idle();
    regw = 1; waddr = 0; wdata = 32'hDEADBEEF; rR1 = 0;
    #2 chk("x0_same", dR1, 0);
    tick();
    regw = 0;
    #2 chk("x0_next", dR1, 0);

    // Same-cycle bypass vs. old value.
    regw = 1; waddr = 5; wdata = 32'h12345678; rR1 = 5;
    #2;
    chk("byp1_same", dR1, 32'h12345678);
    chk("byp0_same", nb_dR1, 0);
    tick();
    regw = 0;
    #2;
    chk("byp1_next", dR1, 32'h12345678);
    chk("byp0_next", nb_dR1, 32'h12345678);

    // Issue x7, hazard on read, write resolves via bypass.
    idle();
    issue = 1; iaddr = 7;
    #2 chk("iss7_nohz", hazard, 0);
    tick();
    issue = 0;
    chk("iss7_npend", npend, 1);
    chk("iss7_npend_nb", nb_npend, 1);
    rR2 = 7;
    #2 chk("iss7_hz", hazard, 1);
    regw = 1; waddr = 7; wdata = 32'hA5A5A5A5;
    #1;
    chk("wb7_hz", hazard, 0);
    chk("wb7_dR2", dR2, 32'hA5A5A5A5);
    chk("wb7_hz_nb", nb_hazard, 1);
    tick();
    regw = 0;
    chk("wb7_npend", npend, 0);
    chk("wb7_npend_nb", nb_npend, 0);
    #1 chk("wb7_hz_after", hazard, 0);

    // Issue blocked while hazard.
    idle();
    issue = 1; iaddr = 3;
    tick();
    issue = 0;
    chk("iss3_npend", npend, 1);
    rR1 = 3; issue = 1; iaddr = 9;
    #2 chk("blk_hz", hazard, 1);
    tick();
    issue = 0;
    chk("blk_npend", npend, 1);
    rR1 = 9;
    #2 chk("blk_busy9", hazard, 0);
    rR1 = 3;
    #1 chk("blk_busy3", hazard, 1);
    rR1 = 0; regw = 1; waddr = 3; wdata = 32'h33;
    tick();
    regw = 0;
    chk("clr3_npend", npend, 0);

    // Issue to x0 discarded.
    issue = 1; iaddr = 0;
    tick();
    issue = 0;
    chk("iss0_npend", npend, 0);

    // Simultaneous write and issue on x4: issue wins, data stored.
    idle();
    issue = 1; iaddr = 4;
    tick();
    chk("iss4_npend", npend, 1);
    regw = 1; waddr = 4; wdata = 32'h1; issue = 1; iaddr = 4;
    tick();
    idle();
    chk("same4_npend", npend, 1);
    rR1 = 4;
    #2;
    chk("same4_busy", hazard, 1);
    chk("same4_data", dR1, 32'h1);
    rR1 = 0; regw = 1; waddr = 4; wdata = 32'h4;
    tick();
    regw = 0;
    chk("clr4_npend", npend, 0);

    // Fill x1..x10, issue x1..x3, then reset with write and issue present.
    idle();
    for (int a = 1; a <= 10; a++) begin
      regw = 1; waddr = 5'(a); wdata = 32'h100 + 32'(a);
      tick();
    end
    regw = 0;
    for (int a = 1; a <= 3; a++) begin
      issue = 1; iaddr = 5'(a);
      tick();
    end
    issue = 0;
    chk("fill_npend", npend, 3);
    rR1 = 10;
    #2 chk("fill_x10", dR1, 32'h10A);
    rR1 = 0;
    reset = 1; regw = 1; waddr = 11; wdata = 32'hBAD; issue = 1; iaddr = 12;
    tick();
    reset = 0;
    idle();
    chk("mrst_npend", npend, 0);
    for (int a = 0; a < 32; a++) begin
      rR1 = 5'(a); rR2 = 5'(a);
      #2;
      chk($sformatf("mrst_dR1_%0d", a), dR1, 0);
      chk($sformatf("mrst_hz_%0d", a), hazard, 0);
      tick();
    end
    chk("mrst_npend_end", npend, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
